// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, ExcCodes and Status/Cause bit positions
package cp0_pkg;

  // CP0 register numbers as seen by MFC0/MTC0
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;
  localparam logic [4:0] CP0_CONFIG   = 5'd16;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Status comes out of reset with only BEV set
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  // Status bit positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;
  localparam int ST_BEV   = 22;

  // Cause bit positions
  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IP_HI  = 15;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  // Address-error exceptions are the only ones that capture BadVAddr
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with prescaler; TI only when CP0_TIMER_INT_EN is defined
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int            PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [31:0]   count_nx;

  assign tick = (presc == PRESC_MAX);

  // Next Count value: a software load beats the prescaled increment
  always_comb begin
    count_nx = count;
    if (count_we) begin
      count_nx = wdata;
    end else if (tick) begin
      count_nx = count + 32'd1;
    end
  end

  // Prescaler restarts on wrap and on any software load of Count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (count_we || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nx;
    end
  end

  // Compare register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare <= '0;
    end else if (compare_we) begin
      compare <= wdata;
    end
  end

`ifdef CP0_TIMER_INT_EN
  // TI rises when Count moves onto Compare; any Compare write acknowledges it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ti <= 1'b0;
    end else if (compare_we) begin
      ti <= 1'b0;
    end else if ((count_nx != count) && (count_nx == compare)) begin
      ti <= 1'b1;
    end
  end
`else
  assign ti = 1'b0;
`endif

endmodule

// File: rtl/cp0_ctrl.sv
// rtl/cp0_ctrl.sv - MIPS32 CP0 register block, exception/ERET and interrupt request; option CP0_TIMER_INT_EN
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int          HW_INT_NUM = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VAL   = 32'h0001_8000,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  mtc0_we,
  input  logic [4:0]            mtc0_addr,
  input  logic [31:0]           mtc0_wdata,
  input  logic [4:0]            mfc0_addr,
  output logic [31:0]           mfc0_rdata,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_pc,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  output logic                  int_req,
  output logic                  exl_out,
  output logic [31:0]           epc_out
);

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic [4:0]  cause_exc;
  logic [1:0]  cause_ip_sw;
  logic [5:0]  ip_hw;
  logic [5:0]  hw_ext;
  logic [7:0]  ip;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;

  // MTC0 strobes after priority filtering: exceptions own Status/Cause/EPC,
  // ERET owns Status; Count and Compare are never touched by either
  logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;
  assign wr_status  = mtc0_we && (mtc0_addr == CP0_STATUS) && !exc_valid && !eret;
  assign wr_cause   = mtc0_we && (mtc0_addr == CP0_CAUSE)  && !exc_valid;
  assign wr_epc     = mtc0_we && (mtc0_addr == CP0_EPC)    && !exc_valid;
  assign wr_count   = mtc0_we && (mtc0_addr == CP0_COUNT);
  assign wr_compare = mtc0_we && (mtc0_addr == CP0_COMPARE);

  // Unused hardware lines are zero-extended so their IP bits read 0
  assign hw_ext = 6'(hw_int);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (mtc0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // Status: exception sets EXL, ERET clears it, otherwise MTC0 writes IM/EXL/IE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_im  <= STATUS_RESET[ST_IM_HI:ST_IM_LO];
      status_exl <= STATUS_RESET[ST_EXL];
      status_ie  <= STATUS_RESET[ST_IE];
    end else if (exc_valid) begin
      status_exl <= 1'b1;
    end else if (eret) begin
      status_exl <= 1'b0;
    end else if (wr_status) begin
      status_im  <= mtc0_wdata[ST_IM_HI:ST_IM_LO];
      status_exl <= mtc0_wdata[ST_EXL];
      status_ie  <= mtc0_wdata[ST_IE];
    end
  end

  // Cause ExcCode/BD on exception entry; BD only on the first (non-nested) entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_exc <= '0;
      cause_bd  <= 1'b0;
    end else if (exc_valid) begin
      cause_exc <= exc_code;
      if (!status_exl) begin
        cause_bd <= exc_bd;
      end
    end
  end

  // Software interrupt bits IP[1:0]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_ip_sw <= '0;
    end else if (wr_cause) begin
      cause_ip_sw <= mtc0_wdata[CA_IP_LO+1:CA_IP_LO];
    end
  end

  // Hardware interrupt lines are sampled every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip_hw <= '0;
    end else begin
      ip_hw <= hw_ext;
    end
  end

  // EPC: held while already in exception level so the outer return point survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc <= '0;
    end else if (exc_valid) begin
      if (!status_exl) begin
        epc <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
      end
    end else if (wr_epc) begin
      epc <= mtc0_wdata;
    end
  end

  // BadVAddr captures only on address-error exceptions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badvaddr <= '0;
    end else if (exc_valid && is_addr_exc(exc_code)) begin
      badvaddr <= exc_badvaddr;
    end
  end

  // IP[7] merges the timer with the top hardware line
  assign ip = {ip_hw[5] | ti, ip_hw[4:0], cause_ip_sw};

  // Assemble architectural Status and Cause views
  always_comb begin
    status_rd                    = '0;
    status_rd[ST_BEV]            = 1'b1;
    status_rd[ST_IM_HI:ST_IM_LO] = status_im;
    status_rd[ST_EXL]            = status_exl;
    status_rd[ST_IE]             = status_ie;
    cause_rd                     = '0;
    cause_rd[CA_BD]              = cause_bd;
    cause_rd[CA_TI]              = ti;
    cause_rd[CA_IP_HI:CA_IP_LO]  = ip;
    cause_rd[CA_EXC_HI:CA_EXC_LO] = cause_exc;
  end

  // MFC0 read mux; unmapped numbers read zero
  always_comb begin
    mfc0_rdata = '0;
    case (mfc0_addr)
      CP0_BADVADDR: mfc0_rdata = badvaddr;
      CP0_COUNT:    mfc0_rdata = count;
      CP0_COMPARE:  mfc0_rdata = compare;
      CP0_STATUS:   mfc0_rdata = status_rd;
      CP0_CAUSE:    mfc0_rdata = cause_rd;
      CP0_EPC:      mfc0_rdata = epc;
      CP0_PRID:     mfc0_rdata = PRID_VAL;
      CP0_CONFIG:   mfc0_rdata = CONFIG_VAL;
      default:      mfc0_rdata = '0;
    endcase
  end

  assign int_req = (|(ip & status_im)) & status_ie & ~status_exl;
  assign exl_out = status_exl;
  assign epc_out = epc;

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb/tb_cp0_ctrl.sv - scoreboard bench for cp0_ctrl; expectations follow CP0_TIMER_INT_EN
module tb_cp0_ctrl;
  import cp0_pkg::*;

  localparam int K_RD  = 0;
  localparam int K_INT = 1;
  localparam int K_EXL = 2;
  localparam int K_EPC = 3;

`ifdef CP0_TIMER_INT_EN
  localparam logic        TIMER_ON  = 1'b1;
  localparam logic [31:0] CAUSE_TMR = 32'h4000_8030;
`else
  localparam logic        TIMER_ON  = 1'b0;
  localparam logic [31:0] CAUSE_TMR = 32'h0000_0030;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  hw_int = '0;
  logic        mtc0_we = 1'b0;
  logic [4:0]  mtc0_addr = '0;
  logic [31:0] mtc0_wdata = '0;
  logic [4:0]  mfc0_addr = '0;
  logic [31:0] mfc0_rdata;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic        exc_bd = 1'b0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_badvaddr = '0;
  logic        eret = 1'b0;
  logic        int_req;
  logic        exl_out;
  logic [31:0] epc_out;

  cp0_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .hw_int       (hw_int),
    .mtc0_we      (mtc0_we),
    .mtc0_addr    (mtc0_addr),
    .mtc0_wdata   (mtc0_wdata),
    .mfc0_addr    (mfc0_addr),
    .mfc0_rdata   (mfc0_rdata),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_bd       (exc_bd),
    .exc_pc       (exc_pc),
    .exc_badvaddr (exc_badvaddr),
    .eret         (eret),
    .int_req      (int_req),
    .exl_out      (exl_out),
    .epc_out      (epc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input int kind, input logic [4:0] addr, input logic [31:0] exp, input string tag);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.exp  = exp;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    push(K_RD, addr, exp, tag);
  endtask

  task automatic sig(input int kind, input logic [31:0] exp, input string tag);
    push(kind, 5'd0, exp, tag);
  endtask

  // Called just after a falling edge; at most four entries so all samples stay in the low phase
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      mfc0_addr = e.addr;
      #1;
      case (e.kind)
        K_RD:    obs = mfc0_rdata;
        K_INT:   obs = {31'd0, int_req};
        K_EXL:   obs = {31'd0, exl_out};
        default: obs = epc_out;
      endcase
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%08h expected=%08h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    mtc0_we    = 1'b1;
    mtc0_addr  = addr;
    mtc0_wdata = data;
    tick();
    mtc0_we    = 1'b0;
  endtask

  task automatic set_exc(input logic v, input logic [4:0] code, input logic bd,
                         input logic [31:0] pc, input logic [31:0] bva);
    exc_valid    = v;
    exc_code     = code;
    exc_bd       = bd;
    exc_pc       = pc;
    exc_badvaddr = bva;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    sig(K_INT, 0, "rst_int_req");
    sig(K_EXL, 0, "rst_exl");
    sig(K_EPC, 0, "rst_epc_out");
    rd(5'd0, 0, "rst_addr0");
    drain();

    rst = 1'b0;
    rd(CP0_STATUS, 32'h0040_0000, "rst_status");
    rd(CP0_CAUSE, 0, "rst_cause");
    rd(CP0_COUNT, 0, "rst_count");
    rd(CP0_BADVADDR, 0, "rst_badvaddr");
    drain();

    repeat (10) tick();
    rd(CP0_COUNT, 32'd5, "count_10_edges");
    rd(CP0_PRID, 32'h0001_8000, "prid");
    rd(CP0_CONFIG, 32'h0000_8000, "config");
    rd(5'd10, 0, "unmapped_10");
    drain();

    // hardware interrupt 0 through IM2 with IE
    mtc0(CP0_STATUS, 32'h0000_0401);
    rd(CP0_STATUS, 32'h0040_0401, "status_wr");
    sig(K_INT, 0, "int_idle");
    drain();
    hw_int = 6'b000001;
    sig(K_INT, 0, "int_same_cycle");
    drain();
    tick();
    sig(K_INT, 1, "int_one_cycle");
    rd(CP0_CAUSE, 32'h0000_0400, "cause_ip2");
    drain();
    hw_int = '0;
    tick();
    sig(K_INT, 0, "int_fall");
    drain();

    // first exception, address error in a delay slot
    set_exc(1'b1, EXC_ADEL, 1'b1, 32'hBFC0_0104, 32'h0000_0003);
    tick();
    set_exc(1'b0, '0, 1'b0, '0, '0);
    rd(CP0_EPC, 32'hBFC0_0100, "exc1_epc");
    rd(CP0_CAUSE, 32'h8000_0010, "exc1_cause");
    rd(CP0_BADVADDR, 32'h0000_0003, "exc1_badvaddr");
    sig(K_EXL, 1, "exc1_exl");
    drain();
    sig(K_EPC, 32'hBFC0_0100, "exc1_epc_out");
    rd(CP0_STATUS, 32'h0040_0403, "exc1_status");
    sig(K_INT, 0, "exc1_int_masked");
    drain();

    // nested exception holds EPC and BD, BadVAddr untouched for SYS
    set_exc(1'b1, EXC_SYS, 1'b0, 32'h8000_0000, 32'h0000_1234);
    tick();
    set_exc(1'b0, '0, 1'b0, '0, '0);
    rd(CP0_EPC, 32'hBFC0_0100, "exc2_epc_held");
    rd(CP0_CAUSE, 32'h8000_0020, "exc2_cause");
    rd(CP0_BADVADDR, 32'h0000_0003, "exc2_badvaddr");
    sig(K_EXL, 1, "exc2_exl");
    drain();

    eret = 1'b1;
    tick();
    eret = 1'b0;
    sig(K_EXL, 0, "eret_exl");
    rd(CP0_STATUS, 32'h0040_0401, "eret_status");
    rd(CP0_EPC, 32'hBFC0_0100, "eret_epc");
    drain();

    // exception + eret + MTC0 Status in one cycle: exception wins
    set_exc(1'b1, EXC_OV, 1'b0, 32'h8000_1000, '0);
    eret = 1'b1;
    mtc0(CP0_STATUS, 32'h0000_0000);
    set_exc(1'b0, '0, 1'b0, '0, '0);
    eret = 1'b0;
    sig(K_EXL, 1, "prio_exl");
    rd(CP0_STATUS, 32'h0040_0403, "prio_status");
    rd(CP0_EPC, 32'h8000_1000, "prio_epc");
    rd(CP0_CAUSE, 32'h0000_0030, "prio_cause");
    drain();

    // eret + MTC0 Status: eret wins
    eret = 1'b1;
    mtc0(CP0_STATUS, 32'h0000_0000);
    eret = 1'b0;
    sig(K_EXL, 0, "eret_prio_exl");
    rd(CP0_STATUS, 32'h0040_0401, "eret_prio_status");
    drain();

    // software interrupt through IM0
    mtc0(CP0_STATUS, 32'h0000_0101);
    sig(K_INT, 0, "sw_int_idle");
    drain();
    mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
    rd(CP0_CAUSE, 32'h0000_0330, "sw_cause");
    sig(K_INT, 1, "sw_int_set");
    drain();
    mtc0(CP0_CAUSE, 32'h0000_0000);
    sig(K_INT, 0, "sw_int_clr");
    drain();

    // timer: Count=0, Compare=20, IM7+IE
    mtc0(CP0_COUNT, 32'd0);
    mtc0(CP0_COMPARE, 32'd20);
    mtc0(CP0_STATUS, 32'h0000_8001);
    rd(CP0_COUNT, 32'd1, "tmr_count_start");
    drain();
    repeat (37) tick();
    rd(CP0_COUNT, 32'd19, "tmr_count_19");
    sig(K_INT, 0, "tmr_int_before");
    drain();
    tick();
    rd(CP0_COUNT, 32'd20, "tmr_count_20");
    sig(K_INT, {31'd0, TIMER_ON}, "tmr_int_hit");
    rd(CP0_CAUSE, CAUSE_TMR, "tmr_cause_hit");
    drain();
    mtc0(CP0_COMPARE, 32'd100);
    sig(K_INT, 0, "tmr_int_ack");
    rd(CP0_COMPARE, 32'd100, "tmr_compare");
    rd(CP0_CAUSE, 32'h0000_0030, "tmr_cause_ack");
    drain();

    // re-arm the timer, then assert reset mid-cycle
    mtc0(CP0_COUNT, 32'd99);
    repeat (2) tick();
    rd(CP0_COUNT, 32'd100, "tmr_count_100");
    rd(CP0_CAUSE, CAUSE_TMR, "tmr_cause_rearm");
    sig(K_INT, {31'd0, TIMER_ON}, "tmr_int_rearm");
    drain();
    #2;
    rst = 1'b1;
    rd(CP0_CAUSE, 0, "async_rst_cause");
    rd(CP0_COUNT, 0, "async_rst_count");
    sig(K_INT, 0, "async_rst_int");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Parametrised MIPS32 coprocessor-0 block holding the privileged registers: BadVAddr, Count, Compare, Status, Cause, EPC, PRId and Config. It sits beside the writeback/exception stage. It does three jobs: services MFC0/MTC0, performs precise exception entry and ERET state updates, and combines hardware, software and timer interrupts into a single request to the pipeline. It generalises the earlier CP0 with these additions:
- a configurable interrupt-line count and Count prescaler;
- a proper Count/Compare timer;
- EXL-aware EPC capture;
- a fixed write-port priority.

## Interface
- HW_INT_NUM, 6: hardware interrupt lines, 1..6, mapped to Cause.IP[2+i].
- COUNT_DIV, 2: clocks per Count increment, ≥1.
- PRID_VAL, 32'h0001_8000: constant PRId value.
- CONFIG_VAL, 32'h0000_8000: constant Config value.

Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- hw_int  in  HW_INT_NUM  level-sensitive external interrupts
- mtc0_we  in  1  MTC0 write strobe
- mtc0_addr  in  5  destination register number
- mtc0_wdata  in  32  write data
- mfc0_addr  in  5  read register number
- mfc0_rdata  out  32  read data (combinational)
- exc_valid  in  1  exception commit strobe
- exc_code  in  5  ExcCode
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_pc  in  32  faulting instruction PC
- exc_badvaddr  in  32  faulting address
- eret  in  1  ERET commit strobe
- int_req  out  1  interrupt pending and enabled
- exl_out  out  1  Status.EXL
- epc_out  out  32  EPC, for the ERET target

## Operation
- Readable registers: 8 BadVAddr (read-only), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config. Every other address reads 0.
- Status writable bits: IM[15:8], EXL[1], IE[0]. BEV[22] always reads 1; all other bits read 0.
- Cause writable bits: IP[9:8] only. IP[7:2] is hardware-driven. BD[31], TI[30] and ExcCode[6:2] are read-only to MTC0.
- Write priority within one cycle, highest first: exc_valid, then eret, then mtc0_we. A lower-priority event on a register the higher one modifies is dropped.
- Exception entry (exc_valid=1):
  - ExcCode <= exc_code; Status.EXL <= 1.
  - If EXL was 0: EPC <= exc_bd ? exc_pc-4 : exc_pc, and Cause.BD <= exc_bd.
  - If EXL was 1: EPC and BD are held.
  - BadVAddr <= exc_badvaddr only when exc_code is 4 (AdEL) or 5 (AdES).
- ERET: Status.EXL <= 0. No other register changes.
- Cause.IP[2+i] <= hw_int[i] every cycle (one register stage). Unused IP bits read 0.
- Interrupt request: int_req = |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL.
- Timer, in sub-module cp0_timer:
  - A prescaler counts 0..COUNT_DIV-1; Count increments (wrapping mod 2^32) when it wraps.
  - TI sets on the cycle Count becomes equal to Compare.
  - TI clears on any MTC0 to Compare.
  - An MTC0 to Count loads Count and clears the prescaler.

## Timing
- Reset values: Status=32'h0040_0000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, prescaler=0. Outputs: int_req=0, exl_out=0, epc_out=0, mfc0_rdata=0 at address 0.
- MTC0, exception entry and ERET update registers at the clock edge. The effect is visible on mfc0_rdata and the outputs the next cycle. There is no same-cycle write forwarding.
- hw_int to int_req latency is 1 cycle. A software IP write or an IM/IE change affects int_req 1 cycle after the write edge.
- COUNT_DIV=2: Count reads 1 after the 2nd edge following reset release.
- Reset mid-operation asynchronously forces all reset values, including TI=0.

## Configuration
- CP0_TIMER_INT_EN defined:
  - Cause.IP[7] = TI | hw_int[5]-sample, when HW_INT_NUM=6.
  - Cause.TI reflects the timer.
- CP0_TIMER_INT_EN undefined:
  - TI is tied 0; Compare remains readable and writable but has no interrupt effect.
  - IP[7] comes from hw_int only.

## Structure
- Package cp0_pkg holds:
  - register number localparams (CP0_BADVADDR=8 … CP0_CONFIG=16);
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12);
  - the Status reset constant;
  - Status/Cause bit-position constants.
- One sub-module, cp0_timer: Count, Compare, prescaler and TI; it accepts write strobes and outputs count, compare and ti.

## Test plan
- Reset, then MFC0 12 gives 32'h0040_0000; MFC0 9 reads 5 after 10 edges with COUNT_DIV=2.
- MTC0 Status=32'h0000_0401, then hw_int[0] held high gives int_req=1 exactly one cycle later. Deassert, and int_req falls one cycle later.
- exc_valid with code 4, bd=1, pc=32'hBFC0_0104, badvaddr=32'h0000_0003:
  - expect EPC=32'hBFC0_0100, Cause=32'h8000_0010, BadVAddr=3, EXL=1.
  - Then a second exception with pc=32'h8000_0000 leaves EPC unchanged.
- Same cycle exc_valid plus eret plus MTC0 Status=0: expect EXL=1 and the Status write dropped.
- CP0_TIMER_INT_EN defined, Compare=20, Status=32'h0000_8001:
  - int_req asserts when Count reaches 20;
  - MTC0 Compare=100 clears TI and int_req next cycle.
- With CP0_TIMER_INT_EN undefined, the same stimulus never asserts int_req.
